// File: rtl/logic_vec_pkg.sv
// Shared definitions for the multi-lane bitwise logic pipeline.
// Op encodings and the per-bit operation evaluator.
package logic_vec_pkg;

    localparam logic [1:0] OP_NOT = 2'd0;
    localparam logic [1:0] OP_AND = 2'd1;
    localparam logic [1:0] OP_OR  = 2'd2;
    localparam logic [1:0] OP_XOR = 2'd3;

    // Ops are bitwise, so evaluating one bit position serves every lane and width.
    function automatic logic eval_bit(input logic [1:0] op, input logic a, input logic b);
        logic r;
        case (op)
            OP_NOT:  r = ~a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/ready register slice: holds a beat and passes it downstream.
// Loads whenever it is empty or its current beat is leaving this cycle.
module pipe_stage #(
    parameter int unsigned DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [DW-1:0] up_data,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic [DW-1:0] dn_data
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    assign up_ready = ~valid_q | dn_ready;
    assign dn_valid = valid_q;
    assign dn_data  = data_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (up_ready) begin
            valid_q <= up_valid;
            // An empty slot keeps its stale data; only real beats overwrite it.
            if (up_valid) begin
                data_q <= up_data;
            end
        end
    end

endmodule

// File: rtl/logic_vec_pipe.sv
// Pipelined multi-lane bitwise logic unit (NOT/AND/OR/XOR) with valid/ready flow.
// Result is computed in front of stage 0; later stages only carry data.
module logic_vec_pipe
    import logic_vec_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             op,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] y
);

    localparam int unsigned DW = LANES * WIDTH;

    logic [DW-1:0] result;

    always_comb begin
        result = '0;
        for (int i = 0; i < DW; i++) begin
            result[i] = eval_bit(op, a[i], b[i]);
        end
    end

    // Per-stage handshake nets live inside each generate block to keep the
    // combinational ready chain free of self-referencing vectors.
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic          up_valid;
        logic          up_ready;
        logic [DW-1:0] up_data;
        logic          dn_valid;
        logic          dn_ready;
        logic [DW-1:0] dn_data;

        if (s == 0) begin : g_first
            assign up_valid = in_valid & ~reset;
            assign up_data  = result;
        end else begin : g_mid
            assign up_valid = g_stage[s-1].dn_valid;
            assign up_data  = g_stage[s-1].dn_data;
        end

        if (s == STAGES - 1) begin : g_last
            assign dn_ready = out_ready;
        end else begin : g_inner
            assign dn_ready = g_stage[s+1].up_ready;
        end

        pipe_stage #(
            .DW(DW)
        ) u_stage (
            .clock    (clock),
            .reset    (reset),
            .up_valid (up_valid),
            .up_ready (up_ready),
            .up_data  (up_data),
            .dn_valid (dn_valid),
            .dn_ready (dn_ready),
            .dn_data  (dn_data)
        );
    end

    assign in_ready  = g_stage[0].up_ready & ~reset;
    assign out_valid = g_stage[STAGES-1].dn_valid;
    assign y         = g_stage[STAGES-1].dn_data;

endmodule

// File: tb/tb_logic_vec_pipe.sv
// Directed self-checking bench for logic_vec_pipe across four parameter sets.
module tb_logic_vec_pipe;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    // Default configuration: WIDTH=8, LANES=4, STAGES=2
    logic        d_iv, d_ir, d_ov, d_or;
    logic [1:0]  d_op;
    logic [31:0] d_a, d_b, d_y;

    // STAGES=3
    logic        t_iv, t_ir, t_ov, t_or;
    logic [1:0]  t_op;
    logic [31:0] t_a, t_b, t_y;

    // WIDTH=1, LANES=1
    logic        w1_iv, w1_ir, w1_ov, w1_or;
    logic [1:0]  w1_op;
    logic [0:0]  w1_a, w1_b, w1_y;

    // WIDTH=13, LANES=3
    logic        w13_iv, w13_ir, w13_ov, w13_or;
    logic [1:0]  w13_op;
    logic [38:0] w13_a, w13_b, w13_y;

    logic_vec_pipe dut (
        .clock(clock), .reset(reset), .in_valid(d_iv), .in_ready(d_ir), .op(d_op),
        .a(d_a), .b(d_b), .out_valid(d_ov), .out_ready(d_or), .y(d_y)
    );

    logic_vec_pipe #(.WIDTH(8), .LANES(4), .STAGES(3)) dut3 (
        .clock(clock), .reset(reset), .in_valid(t_iv), .in_ready(t_ir), .op(t_op),
        .a(t_a), .b(t_b), .out_valid(t_ov), .out_ready(t_or), .y(t_y)
    );

    logic_vec_pipe #(.WIDTH(1), .LANES(1), .STAGES(2)) dut_w1 (
        .clock(clock), .reset(reset), .in_valid(w1_iv), .in_ready(w1_ir), .op(w1_op),
        .a(w1_a), .b(w1_b), .out_valid(w1_ov), .out_ready(w1_or), .y(w1_y)
    );

    logic_vec_pipe #(.WIDTH(13), .LANES(3), .STAGES(2)) dut_w13 (
        .clock(clock), .reset(reset), .in_valid(w13_iv), .in_ready(w13_ir), .op(w13_op),
        .a(w13_a), .b(w13_b), .out_valid(w13_ov), .out_ready(w13_or), .y(w13_y)
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        d_iv = 0; d_op = 0; d_a = '0; d_b = '0; d_or = 1;
        t_iv = 0; t_op = 0; t_a = '0; t_b = '0; t_or = 1;
        w1_iv = 0; w1_op = 0; w1_a = '0; w1_b = '0; w1_or = 1;
        w13_iv = 0; w13_op = 0; w13_a = '0; w13_b = '0; w13_or = 1;
        cyc();
        cyc();
        total++;
        if (d_ir !== 1'b0 || t_ir !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_ready got %b/%b want 0/0", d_ir, t_ir);
        end
        total++;
        if (d_ov !== 1'b0 || d_y !== 32'h0) begin
            bad++;
            $display("FAIL reset_out got ov=%b y=%h want ov=0 y=00000000", d_ov, d_y);
        end
        reset = 1'b0;
        #1;
        total++;
        if (d_ir !== 1'b1) begin
            bad++;
            $display("FAIL release_in_ready got %b want 1", d_ir);
        end
    endtask

    // Runs in the first post-reset cycle.
    task automatic test_not();
        d_iv = 1; d_op = 2'd0; d_a = 32'h03030303; d_or = 1;
        cyc();
        d_iv = 0;
        #1;
        total++;
        if (d_ov !== 1'b0) begin
            bad++;
            $display("FAIL not_early got ov=%b want 0", d_ov);
        end
        cyc();
        total++;
        if (d_ov !== 1'b1 || d_y !== 32'hFCFCFCFC) begin
            bad++;
            $display("FAIL not_result got ov=%b y=%h want ov=1 y=fcfcfcfc", d_ov, d_y);
        end
        cyc();
        total++;
        if (d_ov !== 1'b0) begin
            bad++;
            $display("FAIL not_single got ov=%b want 0", d_ov);
        end
    endtask

    task automatic test_op_sweep();
        logic [31:0] exp_y [4];
        exp_y[0] = 32'hFFFFFF0F;
        exp_y[1] = 32'h00000030;
        exp_y[2] = 32'h000000FC;
        exp_y[3] = 32'h000000CC;
        d_a = 32'h000000F0; d_b = 32'h0000003C; d_or = 1;
        for (int i = 0; i < 4; i++) begin
            d_iv = 1; d_op = 2'(i);
            cyc();
            if (i > 0) begin
                total++;
                if (d_ov !== 1'b1 || d_y !== exp_y[i-1]) begin
                    bad++;
                    $display("FAIL sweep_op%0d got ov=%b y=%h want ov=1 y=%h",
                             i - 1, d_ov, d_y, exp_y[i-1]);
                end
            end
        end
        d_iv = 0;
        cyc();
        total++;
        if (d_ov !== 1'b1 || d_y !== exp_y[3]) begin
            bad++;
            $display("FAIL sweep_op3 got ov=%b y=%h want ov=1 y=%h", d_ov, d_y, exp_y[3]);
        end
        cyc();
        total++;
        if (d_ov !== 1'b0) begin
            bad++;
            $display("FAIL sweep_drained got ov=%b want 0", d_ov);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] beat [4];
        int idx;
        beat[0] = 32'h11111111;
        beat[1] = 32'h22222222;
        beat[2] = 32'h33333333;
        beat[3] = 32'h44444444;
        idx = 0;
        d_or = 0; d_op = 2'd3; d_b = '0;
        for (int c = 0; c < 4; c++) begin
            d_iv = 1; d_a = beat[idx];
            #1;
            if (d_ir) idx++;
            cyc();
            if (c >= 2) begin
                total++;
                if (d_ov !== 1'b1 || d_y !== beat[0]) begin
                    bad++;
                    $display("FAIL bp_stall_hold got ov=%b y=%h want ov=1 y=%h",
                             d_ov, d_y, beat[0]);
                end
            end
        end
        total++;
        if (idx != 2 || d_ir !== 1'b0) begin
            bad++;
            $display("FAIL bp_capacity got accepted=%0d in_ready=%b want 2/0", idx, d_ir);
        end
        d_or = 1;
        for (int k = 0; k < 4; k++) begin
            d_iv = (idx < 4);
            d_a = beat[idx % 4];
            #1;
            total++;
            if (d_ov !== 1'b1 || d_y !== beat[k]) begin
                bad++;
                $display("FAIL bp_drain%0d got ov=%b y=%h want ov=1 y=%h", k, d_ov, d_y, beat[k]);
            end
            if (d_iv && d_ir) idx++;
            cyc();
        end
        d_iv = 0;
        total++;
        if (idx != 4 || d_ov !== 1'b0) begin
            bad++;
            $display("FAIL bp_end got accepted=%0d ov=%b want 4/0", idx, d_ov);
        end
    endtask

    task automatic test_bubble_collapse();
        t_or = 0; t_op = 2'd0; t_iv = 1; t_a = 32'h0000000A;
        cyc();
        t_iv = 0;
        cyc();
        total++;
        if (t_ov !== 1'b0) begin
            bad++;
            $display("FAIL bub_early got ov=%b want 0", t_ov);
        end
        cyc();
        total++;
        if (t_ov !== 1'b1 || t_y !== 32'hFFFFFFF5) begin
            bad++;
            $display("FAIL bub_arrive got ov=%b y=%h want ov=1 y=fffffff5", t_ov, t_y);
        end
        t_iv = 1; t_a = 32'h0000000B;
        #1;
        total++;
        if (t_ir !== 1'b1) begin
            bad++;
            $display("FAIL bub_accept_b got %b want 1", t_ir);
        end
        cyc();
        t_a = 32'h0000000C;
        #1;
        total++;
        if (t_ir !== 1'b1) begin
            bad++;
            $display("FAIL bub_accept_c got %b want 1", t_ir);
        end
        cyc();
        t_a = 32'h0000000D;
        #1;
        total++;
        if (t_ir !== 1'b0 || t_y !== 32'hFFFFFFF5) begin
            bad++;
            $display("FAIL bub_full got in_ready=%b y=%h want 0 fffffff5", t_ir, t_y);
        end
        t_iv = 0; t_or = 1;
        #1;
        total++;
        if (t_y !== 32'hFFFFFFF5) begin
            bad++;
            $display("FAIL bub_out0 got %h want fffffff5", t_y);
        end
        cyc();
        total++;
        if (t_ov !== 1'b1 || t_y !== 32'hFFFFFFF4) begin
            bad++;
            $display("FAIL bub_out1 got ov=%b y=%h want ov=1 y=fffffff4", t_ov, t_y);
        end
        cyc();
        total++;
        if (t_ov !== 1'b1 || t_y !== 32'hFFFFFFF3) begin
            bad++;
            $display("FAIL bub_out2 got ov=%b y=%h want ov=1 y=fffffff3", t_ov, t_y);
        end
        cyc();
        total++;
        if (t_ov !== 1'b0) begin
            bad++;
            $display("FAIL bub_empty got ov=%b want 0", t_ov);
        end
    endtask

    task automatic test_reset_midstream();
        d_or = 0; d_op = 2'd1; d_b = 32'hFFFFFFFF;
        d_iv = 1; d_a = 32'hAAAAAAAA;
        cyc();
        d_a = 32'h55555555;
        cyc();
        d_iv = 0;
        reset = 1;
        cyc();
        total++;
        if (d_ov !== 1'b0 || d_y !== 32'h0 || d_ir !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid got ov=%b y=%h in_ready=%b want 0/00000000/0",
                     d_ov, d_y, d_ir);
        end
        reset = 0; d_or = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (d_ov !== 1'b0) begin
                bad++;
                $display("FAIL rst_stale%0d got ov=%b want 0", i, d_ov);
            end
        end
        d_iv = 1; d_op = 2'd2; d_a = 32'h12340000; d_b = 32'h00005678;
        cyc();
        d_iv = 0;
        #1;
        total++;
        if (d_ov !== 1'b0) begin
            bad++;
            $display("FAIL rst_lat_early got ov=%b want 0", d_ov);
        end
        cyc();
        total++;
        if (d_ov !== 1'b1 || d_y !== 32'h12345678) begin
            bad++;
            $display("FAIL rst_lat got ov=%b y=%h want ov=1 y=12345678", d_ov, d_y);
        end
        cyc();
    endtask

    task automatic test_corners();
        w1_or = 1; w1_iv = 1; w1_op = 2'd3; w1_a = 1'b1; w1_b = 1'b1;
        w13_or = 1; w13_iv = 1; w13_op = 2'd0; w13_a = '0; w13_b = '0;
        cyc();
        w1_b = 1'b0;
        w13_iv = 0;
        cyc();
        w1_iv = 0;
        total++;
        if (w1_ov !== 1'b1 || w1_y !== 1'b0) begin
            bad++;
            $display("FAIL w1_xor11 got ov=%b y=%b want ov=1 y=0", w1_ov, w1_y);
        end
        total++;
        if (w13_ov !== 1'b1 || w13_y !== 39'h7FFFFFFFFF) begin
            bad++;
            $display("FAIL w13_not got ov=%b y=%h want ov=1 y=7fffffffff", w13_ov, w13_y);
        end
        cyc();
        total++;
        if (w1_ov !== 1'b1 || w1_y !== 1'b1) begin
            bad++;
            $display("FAIL w1_xor10 got ov=%b y=%b want ov=1 y=1", w1_ov, w1_y);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_not();
        test_op_sweep();
        test_backpressure();
        test_bubble_collapse();
        test_reset_midstream();
        test_corners();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
